// File: rtl/sort_pkg.sv
// Shared definitions for the merger-tree output stage: record geometry and FSM states.
package sort_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned P          = 8;
   localparam logic [DATA_WIDTH-1:0] SENTINEL = {DATA_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/packer_word_fifo.sv
// First-word fall-through synchronous FIFO holding packed words plus their last tag.
module packer_word_fifo #(
   parameter int unsigned WIDTH = 513,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_free
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             do_pop;

   assign do_pop  = i_pop && !o_empty;
   assign o_data  = mem[rd_ptr];
   assign o_empty = (count == '0);
   assign o_full  = (count == (AW+1)'(DEPTH));
   assign o_free  = (AW+1)'(DEPTH) - count;

   // Storage, pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (i_push) begin
            mem[wr_ptr] <= i_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({i_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/merger_tree_out_packer.sv
// Packs root-merger beats into wide write words, frames each run and reports completion.
module merger_tree_out_packer #(
   parameter int unsigned DATA_WIDTH = sort_pkg::DATA_WIDTH,
   parameter int unsigned P          = sort_pkg::P,
   parameter int unsigned BEATS      = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_start,
   input  logic [CNT_WIDTH-1:0]          i_run_len,
   input  logic [P*DATA_WIDTH-1:0]       i_data,
   input  logic                          i_write,
   output logic                          o_ready,
   output logic [P*BEATS*DATA_WIDTH-1:0] o_word,
   output logic                          o_valid,
   input  logic                          i_word_ready,
   output logic                          o_last,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_overflow
);

   import sort_pkg::*;

   localparam int unsigned BW = P * DATA_WIDTH;
   localparam int unsigned WW = BW * BEATS;
   localparam int unsigned IW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned SH = $clog2(P);
   localparam int unsigned FW = $clog2(FIFO_DEPTH) + 1;

   state_t               state, state_nx;
   logic [CNT_WIDTH-1:0] beats_rem;
   logic [IW-1:0]        beat_idx;
   logic [WW-1:0]        pack_reg, push_word;
   logic                 start_acc, accept, final_beat, push, pop;
   logic                 fifo_empty, fifo_full;
   logic [FW-1:0]        fifo_free;
   logic [WW:0]          head;

   assign start_acc  = (state == IDLE) && i_start;
   assign accept     = (state == RUN) && i_write;
   assign final_beat = (beats_rem == CNT_WIDTH'(1));
   assign push       = accept && (final_beat || (beat_idx == IW'(BEATS - 1)));
   assign pop        = !fifo_empty && i_word_ready;

   assign o_valid = !fifo_empty;
   assign o_word  = head[WW-1:0];
   assign o_last  = head[WW] && !fifo_empty;
   assign o_ready = (state == RUN) && (fifo_free >= FW'(2)) && (beats_rem > CNT_WIDTH'(1));
   assign o_busy  = (state != IDLE);
   assign o_done  = (state == DONE);

   // Word being pushed: stored beats below the current slot, the incoming beat, max-key padding above.
   always_comb begin
      push_word = pack_reg;
      for (int unsigned k = 0; k < BEATS; k++) begin
         if (IW'(k) == beat_idx)     push_word[k*BW +: BW] = i_data;
         else if (IW'(k) > beat_idx) push_word[k*BW +: BW] = {BW{1'b1}};
      end
   end

   // Run bookkeeping: remaining beats, slot within the word, and the partially built word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         beats_rem <= '0;
         beat_idx  <= '0;
         pack_reg  <= '0;
      end else if (start_acc) begin
         beats_rem <= i_run_len >> SH;
         beat_idx  <= '0;
      end else if (accept) begin
         if (beats_rem != '0) beats_rem <= beats_rem - CNT_WIDTH'(1);
         pack_reg[beat_idx*BW +: BW] <= i_data;
         beat_idx <= push ? '0 : beat_idx + IW'(1);
      end
   end

   // Sticky flag for beats arriving outside RUN; a new run clears it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_overflow <= 1'b0;
      else          o_overflow <= (o_overflow && !start_acc) || (i_write && (state != RUN));
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nx;
   end

   // FSM next state.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (i_start) state_nx = (i_run_len == '0) ? DONE : RUN;
         RUN:     if (accept && final_beat) state_nx = DRAIN;
         DRAIN:   if (pop && head[WW]) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Ready throttling leaves room for the one in-flight beat, so the FIFO never overfills.
   always_ff @(posedge i_clk) begin
      if (i_rst_n) assert (!(push && fifo_full));
   end

   packer_word_fifo #(
      .WIDTH (WW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_data  ({final_beat, push_word}),
      .i_pop   (pop),
      .o_data  (head),
      .o_empty (fifo_empty),
      .o_full  (fifo_full),
      .o_free  (fifo_free)
   );

endmodule

// File: tb/tb_merger_tree_out_packer.sv
// Directed bench for merger_tree_out_packer: table of runs plus hand-written corner sequences.
module tb_merger_tree_out_packer;

   logic         clk = 1'b0;
   logic         i_rst_n;
   logic         i_start;
   logic [31:0]  i_run_len;
   logic [255:0] i_data;
   logic         i_write;
   logic         o_ready;
   logic [511:0] o_word;
   logic         o_valid;
   logic         i_word_ready;
   logic         o_last;
   logic         o_busy;
   logic         o_done;
   logic         o_overflow;

   int unsigned  n_checks = 0;
   int unsigned  n_fail   = 0;
   int unsigned  cyc      = 0;
   int unsigned  done_cnt = 0;
   int unsigned  done_cyc = 0;
   int unsigned  hs_cyc   = 0;
   logic [511:0] wq[$];
   logic         lq[$];

   typedef struct {
      int unsigned run_len;
      logic [31:0] base;
      int unsigned exp_words;
      int unsigned exp_pad;
   } vec_t;

   merger_tree_out_packer #(
      .DATA_WIDTH (32),
      .P          (8),
      .BEATS      (2),
      .FIFO_DEPTH (4),
      .CNT_WIDTH  (32)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (i_rst_n),
      .i_start      (i_start),
      .i_run_len    (i_run_len),
      .i_data       (i_data),
      .i_write      (i_write),
      .o_ready      (o_ready),
      .o_word       (o_word),
      .o_valid      (o_valid),
      .i_word_ready (i_word_ready),
      .o_last       (o_last),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_overflow   (o_overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture handshaken words and done pulses mid-cycle.
   always @(negedge clk) begin
      if (i_rst_n && o_valid && i_word_ready) begin
         wq.push_back(o_word);
         lq.push_back(o_last);
         hs_cyc = cyc;
      end
      if (o_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] beat(input logic [31:0] base, input int unsigned b);
      logic [255:0] r;
      for (int unsigned j = 0; j < 8; j++) r[j*32 +: 32] = base + 32'(8*b + j);
      return r;
   endfunction

   function automatic logic [511:0] exp_word(input logic [31:0] base, input int unsigned len,
                                             input int unsigned w);
      logic [511:0] r;
      for (int unsigned j = 0; j < 16; j++)
         r[j*32 +: 32] = (16*w + j < len) ? base + 32'(16*w + j) : 32'hFFFF_FFFF;
      return r;
   endfunction

   function automatic int unsigned pad_count(input logic [511:0] w);
      int unsigned n = 0;
      logic [31:0] rec;
      for (int unsigned j = 0; j < 16; j++) begin
         rec = w[j*32 +: 32];
         if (rec == 32'hFFFF_FFFF) n++;
      end
      return n;
   endfunction

   task automatic start_run(input int unsigned len);
      i_start   = 1'b1;
      i_run_len = len;
      tick();
      i_start   = 1'b0;
   endtask

   // follow=1 models the root merger: a beat is written one cycle after ready was seen high.
   task automatic feed(input int unsigned len, input logic [31:0] base, input bit follow);
      int unsigned nb = len / 8;
      int unsigned sent = 0;
      bit rprev = 1'b0;
      bit w;
      for (int g = 0; g < 400 && sent < nb; g++) begin
         w       = follow ? rprev : 1'b1;
         rprev   = o_ready;
         i_write = w;
         i_data  = beat(base, sent);
         tick();
         if (w) sent++;
      end
      i_write = 1'b0;
      check("feed_beats", sent, nb);
   endtask

   task automatic wait_done(input string name);
      int unsigned d0 = done_cnt;
      int g = 0;
      while (done_cnt == d0 && g < 200) begin
         tick();
         g++;
      end
      tick();
      tick();
      check({name, "_done_pulses"}, done_cnt - d0, 1);
      check({name, "_busy_after"}, o_busy, 0);
   endtask

   initial begin
      vec_t tbl[5];
      int unsigned nw;
      int unsigned d0;

      tbl[0] = '{run_len: 64, base: 32'h1000_0000, exp_words: 4, exp_pad: 0};
      tbl[1] = '{run_len: 24, base: 32'h2000_0000, exp_words: 2, exp_pad: 8};
      tbl[2] = '{run_len: 16, base: 32'h3000_0000, exp_words: 1, exp_pad: 0};
      tbl[3] = '{run_len:  8, base: 32'h4000_0000, exp_words: 1, exp_pad: 8};
      tbl[4] = '{run_len: 40, base: 32'h5000_0000, exp_words: 3, exp_pad: 8};

      i_rst_n = 1'b0; i_start = 1'b0; i_run_len = '0; i_data = '0;
      i_write = 1'b0; i_word_ready = 1'b1;
      #2;
      check("rst_valid", o_valid, 0);
      check("rst_ready", o_ready, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_overflow", o_overflow, 0);
      tick(); tick();
      i_rst_n = 1'b1;
      tick();

      // Table of runs: continuous writes, sink always ready.
      for (int v = 0; v < 5; v++) begin
         wq.delete(); lq.delete();
         start_run(tbl[v].run_len);
         check($sformatf("v%0d_busy", v), o_busy, 1);
         feed(tbl[v].run_len, tbl[v].base, 1'b0);
         wait_done($sformatf("v%0d", v));
         check($sformatf("v%0d_overflow", v), o_overflow, 0);
         check($sformatf("v%0d_words", v), wq.size(), tbl[v].exp_words);
         nw = (wq.size() < tbl[v].exp_words) ? wq.size() : tbl[v].exp_words;
         for (int unsigned w = 0; w < nw; w++) begin
            check($sformatf("v%0d_word%0d", v, w), wq[w], exp_word(tbl[v].base, tbl[v].run_len, w));
            check($sformatf("v%0d_last%0d", v, w), lq[w], (w == tbl[v].exp_words - 1));
         end
         if (nw == tbl[v].exp_words && nw > 0)
            check($sformatf("v%0d_pad", v), pad_count(wq[nw-1]), tbl[v].exp_pad);
         if (v == 0) check("v0_done_latency", done_cyc, hs_cyc + 1);
      end

      // Backpressure: sink stalled, root follows ready with one cycle of latency.
      wq.delete(); lq.delete();
      i_word_ready = 1'b0;
      start_run(56);
      feed(56, 32'h6000_0000, 1'b1);
      tick();
      check("bp_valid", o_valid, 1);
      check("bp_ready_low", o_ready, 0);
      check("bp_overflow", o_overflow, 0);
      check("bp_busy", o_busy, 1);
      i_word_ready = 1'b1;
      wait_done("bp");
      check("bp_words", wq.size(), 4);
      if (wq.size() == 4) begin
         for (int unsigned w = 0; w < 4; w++) begin
            check($sformatf("bp_word%0d", w), wq[w], exp_word(32'h6000_0000, 56, w));
            check($sformatf("bp_last%0d", w), lq[w], (w == 3));
         end
      end

      // Zero-length run: straight to DONE.
      wq.delete(); lq.delete();
      start_run(0);
      check("z_busy", o_busy, 1);
      check("z_done", o_done, 1);
      check("z_valid", o_valid, 0);
      tick();
      check("z_busy_after", o_busy, 0);
      check("z_done_after", o_done, 0);
      check("z_words", wq.size(), 0);

      // Write in IDLE is dropped and flagged until the next start.
      i_write = 1'b1; i_data = beat(32'h7000_0000, 0);
      tick();
      i_write = 1'b0;
      check("ovf_set", o_overflow, 1);
      check("ovf_no_valid", o_valid, 0);
      tick();
      check("ovf_sticky", o_overflow, 1);
      start_run(16);
      check("ovf_cleared", o_overflow, 0);
      feed(16, 32'h7100_0000, 1'b0);
      wait_done("ovf");
      check("ovf_words", wq.size(), 1);
      if (wq.size() == 1) check("ovf_word", wq[0], exp_word(32'h7100_0000, 16, 0));

      // Reset mid-run with two words queued.
      wq.delete(); lq.delete();
      i_word_ready = 1'b0;
      start_run(64);
      for (int unsigned b = 0; b < 4; b++) begin
         i_write = 1'b1; i_data = beat(32'h8000_0000, b);
         tick();
      end
      i_write = 1'b0;
      check("mid_valid", o_valid, 1);
      d0 = done_cnt;
      #3;
      i_rst_n = 1'b0;
      #1;
      check("mid_rst_valid", o_valid, 0);
      check("mid_rst_word", o_word, 0);
      check("mid_rst_last", o_last, 0);
      check("mid_rst_busy", o_busy, 0);
      check("mid_rst_ready", o_ready, 0);
      check("mid_rst_done", o_done, 0);
      tick();
      i_rst_n = 1'b1;
      tick();
      check("mid_no_done", done_cnt, d0);
      i_word_ready = 1'b1;
      start_run(16);
      i_write = 1'b1; i_data = beat(32'h9000_0000, 0);
      tick();
      check("lat_beat0_valid", o_valid, 0);
      i_data = beat(32'h9000_0000, 1);
      tick();
      i_write = 1'b0;
      check("lat_beat1_valid", o_valid, 1);
      check("lat_word", o_word, exp_word(32'h9000_0000, 16, 0));
      check("lat_last", o_last, 1);
      wait_done("post_rst");
      check("post_rst_words", wq.size(), 1);
      if (wq.size() == 1) check("post_rst_word", wq[0], exp_word(32'h9000_0000, 16, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
